cache_nway: RTL and testbench
=============================

// Module: cache_nway
// PURPOSE
//   Parametrised N-way set-associative cache storage array: tags, per-line valid/dirty, true-LRU replacement.
//   Successor to the 2-way store; adds configurable ways/sets/line size, LRU age tracking and a multi-cycle invalidate-all scan.
//   Sits between the CPU-side cache controller FSM and the memory refill/writeback path; the controller sequences it.
// PARAMETERS
//   ADDR_BITS   32  address width
//   LINE_WORDS  4   32-bit words per line (power of 2, >=2)
//   SETS        32  number of sets (power of 2, >=2)
//   WAYS        4   associativity (power of 2, >=2)
// PORTS
//   clk         in   1          clock, all state on rising edge
//   rst         in   1          asynchronous active-high reset
//   addr        in   ADDR_BITS  {tag | set | word | byte[1:0]}
//   load        in   1          CPU read; refreshes LRU on hit
//   store       in   1          refill one word into the fill way; sets valid=1, dirty=0
//   edit        in   1          CPU write on hit; sets dirty=1
//   invalid     in   1          invalidate every way of addr's set
//   flush_all   in   1          pulse: start invalidate-all scan
//   u_b_h_w     in   3          [2]=unsigned, [1]=word, [0]=half, else byte (RV32I LB/LH/LW/LBU/LHU)
//   din         in   32         write/refill data
//   hit         out  1          registered: addr hits a valid way
//   dout        out  32         registered read data (see BEHAVIOUR)
//   valid       out  1          registered valid of victim way
//   dirty       out  1          registered dirty of victim way
//   tag         out  TAG_BITS   registered tag of victim way (for writeback address)
//   victim_way  out  log2(WAYS) registered victim way index
//   write_miss  out  1          registered: edit asserted without hit
//   busy        out  1          invalidate-all scan in progress
// BEHAVIOUR
//   Reset: all valid, dirty, age bits = 0; FSM = IDLE. hit, dout, valid, dirty, tag, victim_way, write_miss, busy = 0.
//     Tag and data arrays are not reset.
//   Latency: all outputs registered, 1 cycle after the addr/command edge; computed from pre-update state.
//   Hit way: lowest-index way with valid && tag match.
//   Victim: lowest-index invalid way if any; else the way with age == WAYS-1.
//   load=1, hit: dout = selected word/half/byte of hit way.
//     Half uses addr[1]; byte uses addr[1:0]; sign- or zero-extend per u_b_h_w[2].
//   load=0: dout = full word of victim way at addr's word offset (writeback read); LRU untouched.
//   edit, hit: merge din into hit word (byte/half lanes per addr, as for load); dirty=1; touch way.
//   edit, miss: no array change; write_miss=1 next cycle.
//   store: fill way = hit way if present (partial refill in progress), else victim.
//     Fill way: write din as full word, set tag, valid=1, dirty=0; touch way.
//   Touch(w): age[w]=0; every way in the set with age < old age[w] increments. Ages stay a permutation of 0..WAYS-1.
//   Same cycle: invalid > store > edit > load for array updates. store+edit: edit ignored, no write_miss.
//     load output is still produced in that cycle.
//   invalid: clears valid, dirty of all ways in the set; ages reset to way index (way0 MRU).
//   FSM IDLE -> SCAN on flush_all.
//     SCAN clears one set per cycle (as invalid), set counter 0..SETS-1; after set SETS-1 -> IDLE.
//     busy=1 throughout SCAN; the scan takes SETS cycles.
//   While busy: load/store/edit/invalid/flush_all ignored; hit=0, write_miss=0.
//   rst mid-scan: immediate return to IDLE, busy=0, all status bits cleared.
// STRUCTURE
//   Shared package cache_pkg: TAG_BITS/SET_W/WORD_W/WAY_W derivations, u_b_h_w encodings.
//     Also holds the load-extract and store-merge functions (shared with the controller).
//   Sub-module cache_lru_set: per-set age vector, touch/reset update and victim select.
//     Instantiated once, muxed by set index.
//   Top holds data/tag arrays, status flops, scan FSM and output registers.
// TESTING
//   1 Reset, then load 0x0000_0104 -> hit=0, valid=0, victim_way=0, busy=0.
//   2 store 4 words at 0x1000_0040.. (din=0xA0..A3), then load LW 0x1000_0044 -> hit=1, dout=0x0000_00A1.
//   3 Word 0x8081_8283 stored, then LB at +3 -> dout=0xFFFF_FF80; LBU -> 0x0000_0080; LH at +2 -> 0xFFFF_8081.
//   4 Fill WAYS+1 distinct tags in set 2; loads touch ways 1..3.
//     Next refill victim_way=0, previous way-0 tag reported on tag; that tag's load misses after refill.
//   5 edit SB 0x55 on hit at byte 1 -> word bits[15:8]=0x55, dirty=1 on victim report.
//     edit to unmapped addr -> write_miss=1, no data change.
//   6 flush_all -> busy=1 for exactly SETS cycles, loads ignored.
//     Afterwards all loads miss; rst asserted mid-scan drops busy immediately.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg                                                            |
// | Shared definitions for the N-way cache store: geometry derivations,  |
// | access-size encodings, scan FSM states, load-extract / store-merge.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cache_pkg;

  // u_b_h_w encodings: [2]=unsigned, [1]=word, [0]=half, otherwise byte
  localparam logic [2:0] UBHW_LB  = 3'b000;
  localparam logic [2:0] UBHW_LH  = 3'b001;
  localparam logic [2:0] UBHW_LW  = 3'b010;
  localparam logic [2:0] UBHW_LBU = 3'b100;
  localparam logic [2:0] UBHW_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Address layout is {tag | set | word | byte[1:0]}
  function automatic int set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_bits(input int addr_bits, input int sets, input int line_words);
    return addr_bits - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  // Pick the addressed byte/half/word out of a line word and extend it
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ubhw);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (ubhw[1])
      return word;
    else if (ubhw[0])
      return ubhw[2] ? {16'b0, h} : {{16{h[15]}}, h};
    else
      return ubhw[2] ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  // Merge the low lanes of din into the addressed byte/half/word
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ubhw);
    logic [31:0] r;
    r = old;
    if (ubhw[1])
      r = din;
    else if (ubhw[0]) begin
      if (off[1]) r[31:16] = din[15:0];
      else        r[15:0]  = din[15:0];
    end else
      r[{off, 3'b000} +: 8] = din[7:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru_set.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_lru_set                                                        |
// | True-LRU age logic for one set: touch / reset-to-index update and    |
// | victim selection. Purely combinational; the top muxes in one set.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int WAYS    = 4,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int AGES_W = WAYS * WAY_W
) (
  input  logic [AGES_W-1:0] ages,
  input  logic [WAYS-1:0]   valid,
  input  logic              touch,
  input  logic [WAY_W-1:0]  touch_way,
  input  logic              reset_ages,
  output logic [AGES_W-1:0] ages_next,
  output logic [WAY_W-1:0]  victim
);

  logic [WAY_W-1:0] old_age;
  logic [WAY_W-1:0] best_age;
  logic             found;

  // Age update: reset to way index (way 0 MRU) or make touch_way MRU
  always_comb begin
    ages_next = ages;
    old_age   = ages[touch_way*WAY_W +: WAY_W];
    if (reset_ages) begin
      for (int w = 0; w < WAYS; w++)
        ages_next[w*WAY_W +: WAY_W] = WAY_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          ages_next[w*WAY_W +: WAY_W] = '0;
        else if (ages[w*WAY_W +: WAY_W] < old_age)
          ages_next[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
      end
    end
  end

  // Victim: lowest invalid way, else oldest way. Oldest is taken as the
  // lowest-index maximum so the all-zero post-reset ages still pick way 0.
  always_comb begin
    victim   = '0;
    found    = 1'b0;
    best_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w*WAY_W +: WAY_W] > best_age) begin
          best_age = ages[w*WAY_W +: WAY_W];
          victim   = WAY_W'(w);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_nway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_nway                                                           |
// | N-way set-associative cache store: data/tag arrays, valid/dirty,     |
// | true-LRU replacement and a one-set-per-cycle invalidate-all scan.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_nway
  import cache_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 32,
  parameter int WAYS       = 4,
  localparam int TAG_BITS  = tag_bits(ADDR_BITS, SETS, LINE_WORDS),
  localparam int WAY_W     = way_w(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 store,
  input  logic                 edit,
  input  logic                 invalid,
  input  logic                 flush_all,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          din,
  output logic                 hit,
  output logic [31:0]          dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [WAY_W-1:0]     victim_way,
  output logic                 write_miss,
  output logic                 busy
);

  localparam int SET_W  = set_w(SETS);
  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int AGES_W = WAYS * WAY_W;

  logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];
  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q  [SETS];
  logic [WAYS-1:0]     dirty_q  [SETS];
  logic [AGES_W-1:0]   age_q    [SETS];

  scan_state_t state, state_next;
  logic [SET_W-1:0] scan_set, scan_next;

  logic [SET_W-1:0]    set_idx, lru_set;
  logic [WORD_W-1:0]   word_idx;
  logic [TAG_BITS-1:0] tag_in;
  logic [1:0]          byte_off;
  logic                cmd_en, hit_any, touch, reset_ages;
  logic [WAY_W-1:0]    hit_way, victim, fill_way, touch_way;
  logic [AGES_W-1:0]   ages_next;
  logic [31:0]         hit_word, victim_word;

  assign byte_off = addr[1:0];
  assign word_idx = addr[2 +: WORD_W];
  assign set_idx  = addr[2+WORD_W +: SET_W];
  assign tag_in   = addr[ADDR_BITS-1 -: TAG_BITS];
  assign busy     = (state == SCAN);
  // flush_all claims its own cycle; commands alongside it are dropped
  assign cmd_en   = (state == IDLE) && !flush_all;
  assign lru_set  = busy ? scan_set : set_idx;

  // Hit detection: lowest-index valid way with matching tag
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == tag_in)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign fill_way    = hit_any ? hit_way : victim;
  assign hit_word    = data_mem[set_idx][hit_way][word_idx];
  assign victim_word = data_mem[set_idx][victim][word_idx];
  assign reset_ages  = busy || (cmd_en && invalid);
  assign touch       = cmd_en && !invalid && (store || ((edit || load) && hit_any));
  assign touch_way   = store ? fill_way : hit_way;

  cache_lru_set #(
    .WAYS(WAYS)
  ) u_lru (
    .ages      (age_q[lru_set]),
    .valid     (valid_q[lru_set]),
    .touch     (touch),
    .touch_way (touch_way),
    .reset_ages(reset_ages),
    .ages_next (ages_next),
    .victim    (victim)
  );

  // Scan FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      scan_set <= '0;
    end else begin
      state    <= state_next;
      scan_set <= scan_next;
    end
  end

  // Scan FSM next state: walk every set once, then return to IDLE
  always_comb begin
    state_next = state;
    scan_next  = scan_set;
    case (state)
      IDLE: if (flush_all) begin
        state_next = SCAN;
        scan_next  = '0;
      end
      SCAN: begin
        scan_next = scan_set + 1'b1;
        if (scan_set == SET_W'(SETS-1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status bits and ages; invalid > store > edit > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      age_q[lru_set] <= ages_next;
      if (busy) begin
        valid_q[scan_set] <= '0;
        dirty_q[scan_set] <= '0;
      end else if (cmd_en) begin
        if (invalid) begin
          valid_q[set_idx] <= '0;
          dirty_q[set_idx] <= '0;
        end else if (store) begin
          valid_q[set_idx][fill_way] <= 1'b1;
          dirty_q[set_idx][fill_way] <= 1'b0;
        end else if (edit && hit_any) begin
          dirty_q[set_idx][hit_way] <= 1'b1;
        end
      end
    end
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (cmd_en && !invalid) begin
      if (store) begin
        data_mem[set_idx][fill_way][word_idx] <= din;
        tag_mem[set_idx][fill_way]            <= tag_in;
      end else if (edit && hit_any) begin
        data_mem[set_idx][hit_way][word_idx] <= store_merge(hit_word, din, byte_off, u_b_h_w);
      end
    end
  end

  // Registered outputs, computed from pre-update state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit        <= 1'b0;
      dout       <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      tag        <= '0;
      victim_way <= '0;
      write_miss <= 1'b0;
    end else begin
      hit        <= cmd_en && hit_any;
      write_miss <= cmd_en && edit && !hit_any && !store && !invalid;
      dout       <= (cmd_en && load && hit_any) ?
                    load_extract(hit_word, byte_off, u_b_h_w) : victim_word;
      valid      <= valid_q[set_idx][victim];
      dirty      <= dirty_q[set_idx][victim];
      tag        <= tag_mem[set_idx][victim];
      victim_way <= victim;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_nway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_nway                                                        |
// | Self-checking bench: directed scenarios plus random traffic against  |
// | a behavioural model of the cache store.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_nway;

  localparam int SETS = 32;
  localparam int WAYS = 4;
  localparam int LW   = 4;
  localparam int TB   = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   addr = '0;
  logic          load = 1'b0, store = 1'b0, edit = 1'b0, invalid = 1'b0, flush_all = 1'b0;
  logic [2:0]    u_b_h_w = 3'b010;
  logic [31:0]   din = '0;
  logic          hit, valid, dirty, write_miss, busy;
  logic [31:0]   dout;
  logic [TB-1:0] tag;
  logic [1:0]    victim_way;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int          m_age   [SETS][WAYS];
  logic [TB-1:0] m_tag [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  bit          m_known [SETS][WAYS][LW];
  bit          m_busy;
  int          m_cnt;

  cache_nway dut (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .store(store), .edit(edit),
    .invalid(invalid), .flush_all(flush_all), .u_b_h_w(u_b_h_w), .din(din),
    .hit(hit), .dout(dout), .valid(valid), .dirty(dirty), .tag(tag),
    .victim_way(victim_way), .write_miss(write_miss), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] k);
    logic [31:0] v;
    if (k[1]) return w;
    if (k[0]) begin
      v = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (!k[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = (w >> (8 * int'(off))) & 32'hFF;
      if (!k[2] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] off, input logic [2:0] k);
    logic [31:0] mask;
    int sh;
    if (k[1]) begin
      mask = 32'hFFFF_FFFF; sh = 0;
    end else if (k[0]) begin
      sh = off[1] ? 16 : 0; mask = 32'hFFFF << sh;
    end else begin
      sh = 8 * int'(off); mask = 32'hFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic m_touch(input int s, input int w);
    int old;
    old = m_age[s][w];
    for (int x = 0; x < WAYS; x++) begin
      if (x == w) m_age[s][x] = 0;
      else if (m_age[s][x] < old) m_age[s][x] = m_age[s][x] + 1;
    end
  endtask

  task automatic m_clear(input int s);
    for (int x = 0; x < WAYS; x++) begin
      m_valid[s][x] = 1'b0;
      m_dirty[s][x] = 1'b0;
      m_age[s][x]   = x;
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++)
      for (int x = 0; x < WAYS; x++) begin
        m_valid[s][x] = 1'b0; m_dirty[s][x] = 1'b0; m_age[s][x] = 0;
      end
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock of stimulus: predict from the model, clock, compare, update model
  task automatic cyc(input logic [31:0] a, input bit ld, input bit st, input bit ed,
                     input bit inv, input bit fl, input logic [2:0] k, input logic [31:0] d);
    int s, wd, hw, vic, fw, best;
    logic [TB-1:0] t;
    bit en, e_known;
    logic [31:0] e_dout;
    addr = a; load = ld; store = st; edit = ed; invalid = inv; flush_all = fl;
    u_b_h_w = k; din = d;
    s  = int'(a[8:4]);
    wd = int'(a[3:2]);
    t  = a[31:9];
    en = !m_busy && !fl;
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
    vic = -1;
    for (int w = 0; w < WAYS; w++)
      if (vic < 0 && !m_valid[s][w]) vic = w;
    if (vic < 0) begin
      best = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_age[s][w] > best) begin best = m_age[s][w]; vic = w; end
    end
    if (en && ld && hw >= 0) begin
      e_dout = m_extract(m_data[s][hw][wd], a[1:0], k); e_known = m_known[s][hw][wd];
    end else begin
      e_dout = m_data[s][vic][wd]; e_known = m_known[s][vic][wd];
    end

    @(posedge clk); #1;

    check("hit", 32'(hit), 32'(en && hw >= 0));
    check("write_miss", 32'(write_miss), 32'(en && ed && hw < 0 && !st && !inv));
    if (en) begin
      check("victim_way", 32'(victim_way), 32'(vic));
      check("valid", 32'(valid), 32'(m_valid[s][vic]));
      check("dirty", 32'(dirty), 32'(m_dirty[s][vic]));
      if (m_valid[s][vic]) check("tag", 32'(tag), 32'(m_tag[s][vic]));
      if (e_known) check("dout", dout, e_dout);
    end

    if (m_busy) begin
      m_clear(m_cnt);
      if (m_cnt == SETS-1) m_busy = 1'b0;
      else m_cnt++;
    end else if (fl) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (inv) begin
      m_clear(s);
    end else if (st) begin
      fw = (hw >= 0) ? hw : vic;
      m_data[s][fw][wd] = d; m_known[s][fw][wd] = 1'b1;
      m_tag[s][fw] = t; m_valid[s][fw] = 1'b1; m_dirty[s][fw] = 1'b0;
      m_touch(s, fw);
    end else begin
      if (ed && hw >= 0) begin
        m_data[s][hw][wd]  = m_merge(m_data[s][hw][wd], d, a[1:0], k);
        m_known[s][hw][wd] = m_known[s][hw][wd] || k[1];
        m_dirty[s][hw]     = 1'b1;
      end
      if ((ed || ld) && hw >= 0) m_touch(s, hw);
    end
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 0; store = 0; edit = 0; invalid = 0; flush_all = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  function automatic logic [31:0] s2(input int t, input int w);
    return (32'(t) << 9) | (32'd2 << 4) | (32'(w) << 2);
  endfunction

  initial begin : main
    int n;
    logic [31:0] a;
    logic [2:0] ks [5];
    ks[0] = 3'b000; ks[1] = 3'b001; ks[2] = 3'b010; ks[3] = 3'b100; ks[4] = 3'b101;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        for (int x = 0; x < LW; x++) begin
          m_known[s][w][x] = 1'b0; m_data[s][w][x] = '0;
        end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_tag[s][w] = '0;

    // 1: reset state, then first load misses
    do_reset();
    check("rst_hit", 32'(hit), 0);
    check("rst_dout", dout, 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_dirty", 32'(dirty), 0);
    check("rst_tag", 32'(tag), 0);
    check("rst_vway", 32'(victim_way), 0);
    check("rst_wmiss", 32'(write_miss), 0);
    check("rst_busy", 32'(busy), 0);
    cyc(32'h0000_0104, 1, 0, 0, 0, 0, 3'b010, 0);
    check("t1_hit", 32'(hit), 0);
    check("t1_vway", 32'(victim_way), 0);

    // 2: refill a line and read back a word
    for (int i = 0; i < 4; i++)
      cyc(32'h1000_0040 + 32'(4*i), 0, 1, 0, 0, 0, 3'b010, 32'hA0 + 32'(i));
    cyc(32'h1000_0044, 1, 0, 0, 0, 0, 3'b010, 0);
    check("t2_hit", 32'(hit), 1);
    check("t2_dout", dout, 32'h0000_00A1);

    // 3: sign/zero extension of byte and half loads
    cyc(32'h1000_0048, 0, 1, 0, 0, 0, 3'b010, 32'h8081_8283);
    cyc(32'h1000_004B, 1, 0, 0, 0, 0, 3'b000, 0);
    check("t3_lb", dout, 32'hFFFF_FF80);
    cyc(32'h1000_004B, 1, 0, 0, 0, 0, 3'b100, 0);
    check("t3_lbu", dout, 32'h0000_0080);
    cyc(32'h1000_004A, 1, 0, 0, 0, 0, 3'b001, 0);
    check("t3_lh", dout, 32'hFFFF_8081);

    // 4: LRU replacement in set 2
    cyc(s2(0, 0), 0, 0, 0, 1, 0, 3'b010, 0);
    for (int t = 1; t <= 4; t++)
      cyc(s2(t, 0), 0, 1, 0, 0, 0, 3'b010, 32'h1111_1111 * 32'(t));
    for (int t = 2; t <= 4; t++)
      cyc(s2(t, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    cyc(s2(5, 0), 0, 1, 0, 0, 0, 3'b010, 32'h5555_5555);
    check("t4_vway", 32'(victim_way), 0);
    check("t4_vtag", 32'(tag), 1);
    check("t4_vvalid", 32'(valid), 1);
    cyc(s2(1, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    check("t4_evicted", 32'(hit), 0);

    // 5: byte edit on hit, dirty on victim report, edit miss
    cyc(s2(2, 0) | 32'd1, 0, 0, 1, 0, 0, 3'b000, 32'h55);
    cyc(s2(5, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    cyc(s2(4, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    cyc(s2(3, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    cyc(s2(2, 0), 0, 0, 0, 0, 0, 3'b010, 0);
    check("t5_vway", 32'(victim_way), 1);
    check("t5_dirty", 32'(dirty), 1);
    check("t5_wb", dout, 32'h2222_5522);
    cyc(s2(9, 0), 0, 0, 1, 0, 0, 3'b010, 32'hDEAD_BEEF);
    check("t5_wmiss", 32'(write_miss), 1);
    cyc(s2(2, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    check("t5_nochange", dout, 32'h2222_5522);

    // 6: invalidate-all scan length, ignored loads, misses afterwards
    cyc(32'h1000_0040, 0, 0, 0, 0, 1, 3'b010, 0);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc(32'h1000_0040, 1, 0, 0, 0, 0, 3'b010, 0);
    end
    check("t6_busy_len", 32'(n), 32'(SETS));
    cyc(32'h1000_0040, 1, 0, 0, 0, 0, 3'b010, 0);
    check("t6_miss_a", 32'(hit), 0);
    cyc(s2(5, 0), 1, 0, 0, 0, 0, 3'b010, 0);
    check("t6_miss_b", 32'(hit), 0);

    // rst in the middle of a scan drops busy without waiting for a clock
    cyc(32'h1000_0040, 0, 0, 0, 0, 1, 3'b010, 0);
    for (int i = 0; i < 5; i++) cyc(32'h1000_0040, 0, 0, 0, 0, 0, 3'b010, 0);
    #2 rst = 1'b1;
    #1 check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_hit", 32'(hit), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();

    // Random traffic on a few hot sets and tags
    for (int i = 0; i < 3000; i++) begin
      a = {23'($urandom_range(0, 5)), 5'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[8:4] = 5'($urandom);
      cyc(a,
          ($urandom_range(0, 1) == 0),
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 499) == 0),
          ks[$urandom_range(0, 4)],
          $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
